// File: rtl/wreg_pkg.sv
// ---------------------------------------------------------------------------
// wreg_pkg
// Shared definitions for the write-register destination tracker:
//   - wreg_sel_t   : destination select encoding
//   - RD_LSB/RD_MSB: position of the rd field inside the immediate
//   - DEF_RA_IDX / DEF_SP_IDX: default link / stack-pointer register indices
// ---------------------------------------------------------------------------
package wreg_pkg;

    typedef enum logic [1:0] {
        SEL_RD = 2'b00,   // rd = imediato[RD_MSB:RD_LSB]
        SEL_RT = 2'b01,   // rt field
        SEL_RA = 2'b10,   // link register
        SEL_SP = 2'b11    // stack pointer
    } wreg_sel_t;

    localparam int RD_LSB     = 11;
    localparam int RD_MSB     = 15;
    localparam int DEF_RA_IDX = 31;
    localparam int DEF_SP_IDX = 29;

endpackage

// File: rtl/wreg_fifo.sv
// ---------------------------------------------------------------------------
// wreg_fifo
// In-order queue of in-flight destination indices with per-entry valid bits.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : append push_data at the tail (caller guarantees space,
//                       or a simultaneous pop when full)
//   pop               : drop the head entry; ignored while empty
//   rs_chk, rt_chk    : indices compared against every valid entry
//   head_data         : head entry, 0 when empty
//   count, full, empty: registered occupancy
//   match_rs/match_rt : per-entry match vectors (valid && data == chk)
// ---------------------------------------------------------------------------
module wreg_fifo
    import wreg_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [REG_W-1:0] push_data,
    input  logic             pop,
    input  logic [REG_W-1:0] rs_chk,
    input  logic [REG_W-1:0] rt_chk,
    output logic [REG_W-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] match_rs,
    output logic [DEPTH-1:0] match_rt
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REG_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             pop_eff;

    // A pop on an empty queue must not move the head pointer.
    assign pop_eff = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop_eff) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop_eff) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer / valid state. When full, head == tail, so a simultaneous
    // push+pop hits the same slot: the push assignment comes last and wins,
    // leaving that slot valid with the new data.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (pop_eff) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    // Payload needs no reset: valid_q qualifies every use.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_rs[i] = valid_q[i] && (data_q[i] == rs_chk);
            match_rt[i] = valid_q[i] && (data_q[i] == rt_chk);
        end
    end

    assign head_data = empty_q ? '0 : data_q[head_q];
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/wreg_dest_tracker.sv
// ---------------------------------------------------------------------------
// wreg_dest_tracker
// Selects the register-file write index, registers it (1-cycle latency) and
// tracks in-flight destinations for RAW hazard checks and back-pressure.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   sel, imediato, rt     : destination select and source fields
//   issue_valid/ready     : issue handshake
//   retire                : oldest in-flight write completed write-back
//   dest_out, dest_valid  : registered destination and 1-cycle update pulse
//   retire_dest           : queue head (0 when empty)
//   rs_chk/rt_chk         : source indices to check
//   hazard_rs/hazard_rt   : source matches a queued destination (never for 0)
//   count, full, empty    : registered queue occupancy
//   err                   : sticky error, only with WREG_TRACK_ERR_EN defined
//
// Handshake: an issue is accepted on a rising clk edge where
// issue_valid && issue_ready. issue_ready = !full || retire, so a retire in
// the same cycle frees a slot for the incoming issue. issue_ready does not
// depend on issue_valid.
//
// Optional build macro: WREG_TRACK_ERR_EN adds the sticky err output, set on
// retire while empty or issue_valid while !issue_ready.
// ---------------------------------------------------------------------------
module wreg_dest_tracker
    import wreg_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int IMM_W  = 16,          // must be >= 16 to hold the rd field
    parameter int DEPTH  = 4,           // power of two, >= 2
    parameter int RA_IDX = DEF_RA_IDX,
    parameter int SP_IDX = DEF_SP_IDX,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic [IMM_W-1:0] imediato,
    input  logic [REG_W-1:0] rt,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             retire,
    output logic [REG_W-1:0] dest_out,
    output logic             dest_valid,
    output logic [REG_W-1:0] retire_dest,
    input  logic [REG_W-1:0] rs_chk,
    input  logic [REG_W-1:0] rt_chk,
    output logic             hazard_rs,
    output logic             hazard_rt,
`ifdef WREG_TRACK_ERR_EN
    output logic             err,
`endif
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [REG_W-1:0] dest_d, dest_q;
    logic             dest_valid_q;
    logic             accept;
    logic [DEPTH-1:0] match_rs, match_rt;
    logic             unused_imm_parity;

    // Only the rd field of the immediate is consumed here.
    assign unused_imm_parity = ^imediato;

    always_comb begin
        dest_d = '0;
        case (wreg_sel_t'(sel))
            SEL_RD:  dest_d = REG_W'(imediato[RD_MSB:RD_LSB]);
            SEL_RT:  dest_d = rt;
            SEL_RA:  dest_d = REG_W'(RA_IDX);
            SEL_SP:  dest_d = REG_W'(SP_IDX);
            default: dest_d = '0;
        endcase
    end

    assign issue_ready = !full || retire;
    assign accept      = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q       <= '0;
            dest_valid_q <= 1'b0;
        end else begin
            dest_valid_q <= accept;
            if (accept) begin
                dest_q <= dest_d;
            end
        end
    end

    assign dest_out   = dest_q;
    assign dest_valid = dest_valid_q;

    wreg_fifo #(
        .REG_W (REG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (dest_d),
        .pop       (retire),
        .rs_chk    (rs_chk),
        .rt_chk    (rt_chk),
        .head_data (retire_dest),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .match_rs  (match_rs),
        .match_rt  (match_rt)
    );

    // Register 0 is hard-wired, so a queued write to it is never a hazard.
    assign hazard_rs = (rs_chk != '0) && (|match_rs);
    assign hazard_rt = (rt_chk != '0) && (|match_rt);

`ifdef WREG_TRACK_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((retire && empty) || (issue_valid && !issue_ready)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_wreg_dest_tracker.sv
// ---------------------------------------------------------------------------
// tb_wreg_dest_tracker
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the tracker.
// ---------------------------------------------------------------------------
module tb_wreg_dest_tracker;

    localparam int REG_W = 5;
    localparam int IMM_W = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       sel;
    logic [IMM_W-1:0] imediato;
    logic [REG_W-1:0] rt;
    logic             issue_valid;
    logic             issue_ready;
    logic             retire;
    logic [REG_W-1:0] dest_out;
    logic             dest_valid;
    logic [REG_W-1:0] retire_dest;
    logic [REG_W-1:0] rs_chk;
    logic [REG_W-1:0] rt_chk;
    logic             hazard_rs;
    logic             hazard_rt;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef WREG_TRACK_ERR_EN
    logic             err;
`endif

    wreg_dest_tracker #(
        .REG_W (REG_W),
        .IMM_W (IMM_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .imediato    (imediato),
        .rt          (rt),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .retire      (retire),
        .dest_out    (dest_out),
        .dest_valid  (dest_valid),
        .retire_dest (retire_dest),
        .rs_chk      (rs_chk),
        .rt_chk      (rt_chk),
        .hazard_rs   (hazard_rs),
        .hazard_rt   (hazard_rt),
`ifdef WREG_TRACK_ERR_EN
        .err         (err),
`endif
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    logic [REG_W-1:0] exp_q[$];     // in-flight destinations, oldest first
    logic [REG_W-1:0] exp_dest;
    logic             exp_dvalid;
    logic             exp_err;
    int               n_checks;
    int               n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [REG_W-1:0] model_dest(input logic [1:0] s,
                                                    input logic [IMM_W-1:0] imm,
                                                    input logic [REG_W-1:0] r);
        case (s)
            2'd0:    return imm[15:11];
            2'd1:    return r;
            2'd2:    return 5'd31;
            default: return 5'd29;
        endcase
    endfunction

    function automatic logic queued(input logic [REG_W-1:0] idx);
        if (idx == 0) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_regs();
        check("dest_out",   dest_out,   exp_dest);
        check("dest_valid", dest_valid, exp_dvalid);
        check("count",      count,      exp_q.size());
        check("full",       full,       exp_q.size() == DEPTH);
        check("empty",      empty,      exp_q.size() == 0);
`ifdef WREG_TRACK_ERR_EN
        check("err",        err,        exp_err);
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns just after the next one.
    task automatic step(input logic iv, input logic [1:0] s, input logic [IMM_W-1:0] imm,
                        input logic [REG_W-1:0] rtv, input logic ret,
                        input logic [REG_W-1:0] rsc, input logic [REG_W-1:0] rtc);
        logic             exp_ready;
        logic [REG_W-1:0] d;
        issue_valid = iv;
        sel         = s;
        imediato    = imm;
        rt          = rtv;
        retire      = ret;
        rs_chk      = rsc;
        rt_chk      = rtc;
        #1;
        exp_ready = (exp_q.size() < DEPTH) || ret;
        check("issue_ready", issue_ready, exp_ready);
        check("hazard_rs",   hazard_rs,   queued(rsc));
        check("hazard_rt",   hazard_rt,   queued(rtc));
        check("retire_dest", retire_dest, (exp_q.size() > 0) ? exp_q[0] : '0);
        d = model_dest(s, imm, rtv);
        @(posedge clk);
        if (ret && exp_q.size() == 0) exp_err = 1'b1;
        if (iv && !exp_ready) exp_err = 1'b1;
        if (ret && exp_q.size() > 0) void'(exp_q.pop_front());
        if (iv && exp_ready) begin
            exp_q.push_back(d);
            exp_dest = d;
        end
        exp_dvalid = iv && exp_ready;
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle();
        step(1'b0, 2'd0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic issue_rt(input logic [REG_W-1:0] r, input logic ret);
        step(1'b1, 2'd1, '0, r, ret, '0, '0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        issue_valid = 1'b0;
        retire      = 1'b0;
        @(posedge clk);
        exp_q.delete();
        exp_dest   = '0;
        exp_dvalid = 1'b0;
        exp_err    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_regs();
        check("rst_hazard_rs",   hazard_rs,   1'b0);
        check("rst_hazard_rt",   hazard_rt,   1'b0);
        check("rst_retire_dest", retire_dest, '0);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_err     = 1'b0;
        exp_dest    = '0;
        exp_dvalid  = 1'b0;
        reset       = 1'b1;
        sel         = '0;
        imediato    = '0;
        rt          = '0;
        issue_valid = 1'b0;
        retire      = 1'b0;
        rs_chk      = '0;
        rt_chk      = '0;
        @(negedge clk);
        do_reset();

        // rd field selection
        step(1'b1, 2'd0, 16'h5800, '0, 1'b0, '0, '0);
        check("tp_rd_dest", dest_out, 5'd11);
        idle();
        check("tp_rd_head", retire_dest, 5'd11);
        step(1'b0, 2'd0, '0, '0, 1'b1, '0, '0);

        // rt, RA, SP selections and hazard lookups
        issue_rt(5'd7, 1'b0);
        step(1'b1, 2'd2, '0, '0, 1'b0, '0, '0);
        step(1'b1, 2'd3, '0, '0, 1'b0, '0, '0);
        step(1'b0, 2'd0, '0, '0, 1'b0, 5'd31, 5'd8);
        check("tp_hz_rs31", hazard_rs, 1'b1);
        check("tp_hz_rt8",  hazard_rt, 1'b0);

        // fill, then issue+retire at full
        issue_rt(5'd12, 1'b0);
        check("tp_full", full, 1'b1);
        step(1'b1, 2'd1, '0, 5'd13, 1'b0, '0, '0);   // rejected
        issue_rt(5'd14, 1'b1);                       // push and pop at full
        check("tp_full_cnt", count, 3'd4);
        check("tp_full_head", retire_dest, 5'd31);

        // drain, then retire on empty
        repeat (5) step(1'b0, 2'd0, '0, '0, 1'b1, '0, '0);
        check("tp_empty", empty, 1'b1);

        do_reset();

        // destination 0 never hazards
        issue_rt(5'd0, 1'b0);
        step(1'b0, 2'd0, '0, '0, 1'b0, 5'd0, 5'd0);
        check("tp_zero_hz", hazard_rs, 1'b0);
        step(1'b0, 2'd0, '0, '0, 1'b1, '0, '0);

        // wrap: hold count at 2 through 10 push+pop cycles
        issue_rt(5'd3, 1'b0);
        issue_rt(5'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            issue_rt(5'($urandom_range(1, 31)), 1'b1);
            check("wrap_cnt", count, 3'd2);
        end

        // reset mid-stream while checking a queued index
        rs_chk = exp_q[0];
        rt_chk = exp_q[1];
        do_reset();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [REG_W-1:0] rsc, rtc;
            rsc = 5'($urandom_range(0, 31));
            rtc = 5'($urandom_range(0, 31));
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
                rsc = exp_q[$urandom_range(0, exp_q.size() - 1)];
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
                rtc = exp_q[$urandom_range(0, exp_q.size() - 1)];
            step(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                 16'($urandom), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 2) == 0), rsc, rtc);
            if (n == 200) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
